// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes and the datapath mux/ALU select values.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_JR      = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [1:0] SRCB_BREG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REGA   = 2'b11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // R-type funct codes that the ALU actually implements.
    function automatic logic is_rtype_alu(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle: instruction fields and zero flag in,
// mux selects, enables and debug state out.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, halted, state
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, halted, state
    );
endinterface

// File: rtl/multicycle_alu_decoder.sv
// Combinational ALU decoder: aluop selects add/sub directly or defers to funct.
module multicycle_alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath with optional memory wait
// states on FETCH, MEMRD and MEMWR.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_ctrl_if.master bus
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;

    logic       mem_state;
    logic       mem_done;

    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcwrite, branch, halted;
    aluop_t     aluop;
    logic [2:0] alucontrol;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR);
    assign mem_done  = (wait_q == WAIT_LAST);

    // The counter rests at zero outside memory states, so entry and
    // completion both see it cleared without a separate clear term.
    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        if (mem_state && !mem_done) begin
            wait_d = wait_q + 4'd1;
        end
        case (state_q)
            S_FETCH: if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (bus.funct == FN_JR)          state_d = S_JR;
                        else if (is_rtype_alu(bus.funct)) state_d = S_EXECUTE;
                        else                              state_d = S_ILLEGAL;
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_done) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_done) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_JR:      state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_BREG;
        pcsrc    = PC_ALURES;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        halted   = 1'b0;
        aluop    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                irwrite = mem_done;
                pcwrite = mem_done;
            end
            S_DECODE: alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = mem_done;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
            S_JR: begin
                pcsrc   = PC_REGA;
                pcwrite = 1'b1;
            end
            S_ILLEGAL: halted = 1'b1;
            default: ;
        endcase
    end

    multicycle_alu_decoder u_alu_dec (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (alucontrol)
    );

    assign bus.iord       = iord;
    assign bus.memwrite   = memwrite;
    assign bus.irwrite    = irwrite;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.regwrite   = regwrite;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.pcen       = pcwrite | (branch & bus.zero);
    assign bus.halted     = halted;
    assign bus.state      = state_q;

endmodule
